// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: default geometries and the wrap-at-DEPTH pointer increment.
// No ports (package).
package fifo_pkg;

  // Widest pointer needed for the largest supported depth (1024 entries).
  localparam int unsigned FIFO_PTR_MAX_W = 10;

  // Default geometries of the acknowledge and data FIFOs.
  localparam int unsigned ACK_FIFO_WIDTH  = 64;
  localparam int unsigned ACK_FIFO_DEPTH  = 16;
  localparam int unsigned DATA_FIFO_WIDTH = 16;
  localparam int unsigned DATA_FIFO_DEPTH = 64;

  typedef logic [FIFO_PTR_MAX_W-1:0] fifo_ptr_t;

  // Advance a pointer by one.
  // It wraps from depth-1 to 0 by explicit compare, so depth need not be a power of two.
  function automatic fifo_ptr_t fifo_ptr_next(input fifo_ptr_t ptr, input int unsigned depth);
    fifo_ptr_t nxt;
    if (32'(ptr) == depth - 32'd1) begin
      nxt = '0;
    end else begin
      nxt = ptr + fifo_ptr_t'(1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/fifo_sdp_ram.sv
// Simple dual-port storage array: registered write, asynchronous read.
// Kept separate so a vendor RAM macro can replace it.
// Ports:
//   i_clk   - write clock
//   i_we    - write enable
//   i_waddr - write address
//   i_wdata - write data
//   i_raddr - read address
//   o_rdata - read data (combinational from i_raddr)
module fifo_sdp_ram #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Write port; contents are deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock parametrised FIFO with programmable almost-full/almost-empty thresholds,
// occupancy count, optional first-word-fall-through, handshake strobes and synchronous flush.
// Ports:
//   CLK       - clock, rising edge
//   RESET     - synchronous reset, active-high
//   FLUSH     - synchronous clear of contents (Q holds its value)
//   WE / RE   - write / read requests
//   DATA      - write data
//   AFVAL     - almost-full threshold (AFULL = COUNT >= AFVAL)
//   AEVAL     - almost-empty threshold (AEMPTY = COUNT <= AEVAL)
//   Q         - read data (registered, or head word when FWFT=1)
//   FULL, EMPTY, AFULL, AEMPTY - registered status flags
//   COUNT     - current occupancy
//   WACK      - accepted-write strobe
//   DVLD      - read-data-valid (pulse; level ~EMPTY when FWFT=1)
//   OVERFLOW  - rejected-write strobe
//   UNDERFLOW - rejected-read strobe
module sync_fifo_prog
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_FIFO_WIDTH,
  parameter int unsigned DEPTH = DATA_FIFO_DEPTH,
  parameter int unsigned FWFT  = 0,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             FLUSH,
  input  logic             WE,
  input  logic             RE,
  input  logic [WIDTH-1:0] DATA,
  input  logic [CW-1:0]    AFVAL,
  input  logic [CW-1:0]    AEVAL,
  output logic [WIDTH-1:0] Q,
  output logic             FULL,
  output logic             EMPTY,
  output logic             AFULL,
  output logic             AEMPTY,
  output logic [CW-1:0]    COUNT,
  output logic             WACK,
  output logic             DVLD,
  output logic             OVERFLOW,
  output logic             UNDERFLOW
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             r_full;
  logic             r_empty;
  logic             r_afull;
  logic             r_aempty;
  logic             r_wack;
  logic             r_dvld;
  logic             r_ovf;
  logic             r_unf;
  logic [WIDTH-1:0] r_q;

  logic             w_rd_ok;
  logic             w_wr_ok;
  logic             w_mem_we;
  logic [CW-1:0]    w_count_nxt;
  logic [WIDTH-1:0] w_rdata;

  // Acceptance: a full FIFO takes a write only when a read frees a slot in the same cycle.
  assign w_rd_ok  = RE & ~r_empty;
  assign w_wr_ok  = WE & (~r_full | w_rd_ok);
  assign w_mem_we = w_wr_ok & ~FLUSH & ~RESET;

  // Next occupancy; simultaneous accepted read and write cancel out.
  always_comb begin
    w_count_nxt = r_count;
    if (w_wr_ok && !w_rd_ok) begin
      w_count_nxt = r_count + CW'(1);
    end else if (!w_wr_ok && w_rd_ok) begin
      w_count_nxt = r_count - CW'(1);
    end
  end

  fifo_sdp_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .i_clk   (CLK),
    .i_we    (w_mem_we),
    .i_waddr (r_wptr),
    .i_wdata (DATA),
    .i_raddr (r_rptr),
    .o_rdata (w_rdata)
  );

  // Control state.
  // Flags are derived from next-count so they line up with the updated COUNT.
  always_ff @(posedge CLK) begin
    if (RESET || FLUSH) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_afull  <= 1'b0;
      r_aempty <= 1'b1;
      r_wack   <= 1'b0;
      r_dvld   <= 1'b0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
      // Flush keeps the last read word; only reset clears it.
      if (RESET) begin
        r_q <= '0;
      end
    end else begin
      if (w_wr_ok) begin
        r_wptr <= AW'(fifo_ptr_next(fifo_ptr_t'(r_wptr), DEPTH));
      end
      if (w_rd_ok) begin
        r_rptr <= AW'(fifo_ptr_next(fifo_ptr_t'(r_rptr), DEPTH));
        r_q    <= w_rdata;
      end
      r_count  <= w_count_nxt;
      r_full   <= (w_count_nxt == CW'(DEPTH));
      r_empty  <= (w_count_nxt == '0);
      r_afull  <= (w_count_nxt >= AFVAL);
      r_aempty <= (w_count_nxt <= AEVAL);
      r_wack   <= w_wr_ok;
      r_dvld   <= w_rd_ok;
      r_ovf    <= WE & ~w_wr_ok;
      r_unf    <= RE & ~w_rd_ok;
    end
  end

  // Read-side presentation: head word straight from the array in FWFT mode.
  generate
    if (FWFT != 0) begin : g_fwft
      assign Q    = w_rdata;
      assign DVLD = ~r_empty;
    end else begin : g_std
      assign Q    = r_q;
      assign DVLD = r_dvld;
    end
  endgenerate

  assign FULL      = r_full;
  assign EMPTY     = r_empty;
  assign AFULL     = r_afull;
  assign AEMPTY    = r_aempty;
  assign COUNT     = r_count;
  assign WACK      = r_wack;
  assign OVERFLOW  = r_ovf;
  assign UNDERFLOW = r_unf;

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Directed bench for sync_fifo_prog.
// Instance a: 16x64 registered-read FIFO.
// Instance b: 16x5 FWFT FIFO, driven from a vector table.
module tb_sync_fifo_prog;

  localparam int unsigned W   = 16;
  localparam int unsigned DA  = 64;
  localparam int unsigned CWA = $clog2(DA + 1);
  localparam int unsigned DB  = 5;
  localparam int unsigned CWB = $clog2(DB + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance a signals
  logic           a_reset, a_flush, a_we, a_re;
  logic [W-1:0]   a_data, a_q;
  logic [CWA-1:0] a_afval, a_aeval, a_count;
  logic           a_full, a_empty, a_afull, a_aempty, a_wack, a_dvld, a_ovf, a_unf;

  // Instance b signals
  logic           b_reset, b_flush, b_we, b_re;
  logic [W-1:0]   b_data, b_q;
  logic [CWB-1:0] b_afval, b_aeval, b_count;
  logic           b_full, b_empty, b_afull, b_aempty, b_wack, b_dvld, b_ovf, b_unf;

  sync_fifo_prog #(.WIDTH(W), .DEPTH(DA), .FWFT(0)) u_dut_a (
    .CLK(clk), .RESET(a_reset), .FLUSH(a_flush), .WE(a_we), .RE(a_re), .DATA(a_data),
    .AFVAL(a_afval), .AEVAL(a_aeval), .Q(a_q), .FULL(a_full), .EMPTY(a_empty),
    .AFULL(a_afull), .AEMPTY(a_aempty), .COUNT(a_count), .WACK(a_wack), .DVLD(a_dvld),
    .OVERFLOW(a_ovf), .UNDERFLOW(a_unf)
  );

  sync_fifo_prog #(.WIDTH(W), .DEPTH(DB), .FWFT(1)) u_dut_b (
    .CLK(clk), .RESET(b_reset), .FLUSH(b_flush), .WE(b_we), .RE(b_re), .DATA(b_data),
    .AFVAL(b_afval), .AEVAL(b_aeval), .Q(b_q), .FULL(b_full), .EMPTY(b_empty),
    .AFULL(b_afull), .AEMPTY(b_aempty), .COUNT(b_count), .WACK(b_wack), .DVLD(b_dvld),
    .OVERFLOW(b_ovf), .UNDERFLOW(b_unf)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        we, re, flush;
    logic [15:0] data;
    int          cnt;
    logic        empty, full, afull, aempty, wack, ovf, unf, dvld, qchk;
    logic [15:0] q;
  } vec_t;

  vec_t vt[16];

  function automatic vec_t mk(input logic we, re, fl, input logic [15:0] data, input int cnt,
                              input logic emp, full, af, ae, wack, ovf, unf, dvld, qchk,
                              input logic [15:0] q);
    vec_t v;
    v.we = we; v.re = re; v.flush = fl; v.data = data; v.cnt = cnt;
    v.empty = emp; v.full = full; v.afull = af; v.aempty = ae; v.wack = wack;
    v.ovf = ovf; v.unf = unf; v.dvld = dvld; v.qchk = qchk; v.q = q;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_a(input string tag, input int cnt, input bit emp, full, af, ae,
                       wack, ovf, unf, dvld);
    chk({tag, ".count"},  32'(a_count),  32'(cnt));
    chk({tag, ".empty"},  32'(a_empty),  32'(emp));
    chk({tag, ".full"},   32'(a_full),   32'(full));
    chk({tag, ".afull"},  32'(a_afull),  32'(af));
    chk({tag, ".aempty"}, 32'(a_aempty), 32'(ae));
    chk({tag, ".wack"},   32'(a_wack),   32'(wack));
    chk({tag, ".ovf"},    32'(a_ovf),    32'(ovf));
    chk({tag, ".unf"},    32'(a_unf),    32'(unf));
    chk({tag, ".dvld"},   32'(a_dvld),   32'(dvld));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] mq[$];
  logic [15:0] mqout;

  initial begin
    vt[0]  = mk(1,0,0,16'hA5A5, 1, 0,0,0,1, 1,0,0,1, 1,16'hA5A5);
    vt[1]  = mk(1,0,0,16'h0001, 2, 0,0,0,0, 1,0,0,1, 1,16'hA5A5);
    vt[2]  = mk(1,0,0,16'h0002, 3, 0,0,0,0, 1,0,0,1, 1,16'hA5A5);
    vt[3]  = mk(1,0,0,16'h0003, 4, 0,0,1,0, 1,0,0,1, 1,16'hA5A5);
    vt[4]  = mk(1,0,0,16'h0004, 5, 0,1,1,0, 1,0,0,1, 1,16'hA5A5);
    vt[5]  = mk(1,0,0,16'h0005, 5, 0,1,1,0, 0,1,0,1, 1,16'hA5A5);
    vt[6]  = mk(1,1,0,16'h0006, 5, 0,1,1,0, 1,0,0,1, 1,16'h0001);
    vt[7]  = mk(0,1,0,16'h0000, 4, 0,0,1,0, 0,0,0,1, 1,16'h0002);
    vt[8]  = mk(0,1,0,16'h0000, 3, 0,0,0,0, 0,0,0,1, 1,16'h0003);
    vt[9]  = mk(0,1,0,16'h0000, 2, 0,0,0,0, 0,0,0,1, 1,16'h0004);
    vt[10] = mk(0,1,0,16'h0000, 1, 0,0,0,1, 0,0,0,1, 1,16'h0006);
    vt[11] = mk(0,1,0,16'h0000, 0, 1,0,0,1, 0,0,0,0, 0,16'h0000);
    vt[12] = mk(0,1,0,16'h0000, 0, 1,0,0,1, 0,0,1,0, 0,16'h0000);
    vt[13] = mk(1,1,0,16'h0007, 1, 0,0,0,1, 1,0,1,1, 1,16'h0007);
    vt[14] = mk(1,0,1,16'h0008, 0, 1,0,0,1, 0,0,0,0, 0,16'h0000);
    vt[15] = mk(0,0,0,16'h0000, 0, 1,0,0,1, 0,0,0,0, 0,16'h0000);

    a_reset = 1'b1; a_flush = 1'b0; a_we = 1'b0; a_re = 1'b0; a_data = '0;
    a_afval = CWA'(60); a_aeval = CWA'(3);
    b_reset = 1'b1; b_flush = 1'b0; b_we = 1'b0; b_re = 1'b0; b_data = '0;
    b_afval = CWB'(4); b_aeval = CWB'(1);

    // Reset and idle
    step(); step();
    chk_a("rst", 0, 1, 0, 0, 1, 0, 0, 0, 0);
    chk("rst.q", 32'(a_q), 32'h0);
    a_reset = 1'b0;
    step();
    chk_a("idle", 0, 1, 0, 0, 1, 0, 0, 0, 0);

    // Fill to full with 0x0000..0x003F
    for (int i = 0; i < 64; i++) begin
      a_we = 1'b1; a_data = 16'(i);
      step();
      chk_a("fill", i + 1, 0, (i + 1) == 64, (i + 1) >= 60, (i + 1) <= 3, 1, 0, 0, 0);
    end
    a_data = 16'h0040;
    step();
    chk_a("ovf", 64, 0, 1, 1, 0, 0, 1, 0, 0);
    a_we = 1'b0;
    step();
    chk_a("ovf_end", 64, 0, 1, 1, 0, 0, 0, 0, 0);

    // Drain, registered read
    for (int i = 0; i < 64; i++) begin
      a_re = 1'b1;
      step();
      chk_a("drain", 63 - i, (63 - i) == 0, 0, (63 - i) >= 60, (63 - i) <= 3, 0, 0, 0, 1);
      chk("drain.q", 32'(a_q), 32'(i));
    end
    step();
    chk_a("unf", 0, 1, 0, 0, 1, 0, 0, 1, 0);
    chk("unf.q", 32'(a_q), 32'h3F);

    // Simultaneous WE/RE at empty: write accepted, read rejected
    a_we = 1'b1; a_data = 16'h0055;
    step();
    chk_a("wr_empty", 1, 0, 0, 0, 1, 1, 0, 1, 0);
    a_re = 1'b0;
    for (int i = 1; i < 64; i++) begin
      a_data = 16'(16'h0100 + i);
      step();
    end
    chk_a("refill", 64, 0, 1, 1, 0, 1, 0, 0, 0);

    // Threshold change with no traffic
    a_we = 1'b0; a_aeval = CWA'(64);
    step();
    chk_a("aeval64", 64, 0, 1, 1, 1, 0, 0, 0, 0);
    a_aeval = CWA'(3);
    step();
    chk_a("aeval3", 64, 0, 1, 1, 0, 0, 0, 0, 0);

    // Simultaneous WE/RE at full
    a_we = 1'b1; a_re = 1'b1; a_data = 16'hBEEF;
    step();
    chk_a("wr_full", 64, 0, 1, 1, 0, 1, 0, 0, 1);
    chk("wr_full.q", 32'(a_q), 32'h0055);

    // Flush from full, then flush at count 10 with WE
    a_we = 1'b0; a_re = 1'b0; a_flush = 1'b1;
    step();
    chk_a("flush_full", 0, 1, 0, 0, 1, 0, 0, 0, 0);
    chk("flush_full.q", 32'(a_q), 32'h0055);
    a_flush = 1'b0;
    for (int i = 0; i < 10; i++) begin
      a_we = 1'b1; a_data = 16'(16'h0300 + i);
      step();
    end
    chk("pre_flush.count", 32'(a_count), 32'd10);
    a_flush = 1'b1; a_data = 16'h03FF;
    step();
    chk_a("flush10", 0, 1, 0, 0, 1, 0, 0, 0, 0);
    chk("flush10.q", 32'(a_q), 32'h0055);
    a_flush = 1'b0; a_we = 1'b0;
    step();
    chk_a("flush_idle", 0, 1, 0, 0, 1, 0, 0, 0, 0);

    // Mid-fill reset with WE
    for (int i = 0; i < 5; i++) begin
      a_we = 1'b1; a_data = 16'(16'h0400 + i);
      step();
    end
    a_reset = 1'b1;
    step();
    chk_a("rst_mid", 0, 1, 0, 0, 1, 0, 0, 0, 0);
    chk("rst_mid.q", 32'(a_q), 32'h0);
    a_reset = 1'b0; a_we = 1'b0;
    a_afval = CWA'(0);
    step();
    chk_a("afval0", 0, 1, 0, 1, 1, 0, 0, 0, 0);
    a_afval = CWA'(60);
    step();
    chk_a("afval60", 0, 1, 0, 0, 1, 0, 0, 0, 0);

    // Mixed traffic against a queue model
    mq.delete();
    mqout = 16'h0;
    for (int c = 0; c < 200; c++) begin
      bit we, re, rdok, wrok;
      logic [15:0] d;
      int sz;
      we = ($urandom_range(0, 9) < 6);
      re = ($urandom_range(0, 9) < 5);
      d  = 16'($urandom);
      rdok = re && (mq.size() > 0);
      wrok = we && ((mq.size() < 64) || rdok);
      if (rdok) mqout = mq.pop_front();
      if (wrok) mq.push_back(d);
      sz = mq.size();
      a_we = we; a_re = re; a_data = d;
      step();
      chk_a("mix", sz, sz == 0, sz == 64, sz >= 60, sz <= 3, wrok, we && !wrok, re && !rdok, rdok);
      chk("mix.q", 32'(a_q), 32'(mqout));
    end
    a_we = 1'b0; a_re = 1'b0;

    // FWFT instance, depth 5
    step();
    chk("b_rst.count", 32'(b_count), 32'd0);
    chk("b_rst.empty", 32'(b_empty), 32'd1);
    chk("b_rst.dvld",  32'(b_dvld),  32'd0);
    b_reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      b_we = vt[i].we; b_re = vt[i].re; b_flush = vt[i].flush; b_data = vt[i].data;
      step();
      chk($sformatf("v%0d.count", i),  32'(b_count),  32'(vt[i].cnt));
      chk($sformatf("v%0d.empty", i),  32'(b_empty),  32'(vt[i].empty));
      chk($sformatf("v%0d.full", i),   32'(b_full),   32'(vt[i].full));
      chk($sformatf("v%0d.afull", i),  32'(b_afull),  32'(vt[i].afull));
      chk($sformatf("v%0d.aempty", i), 32'(b_aempty), 32'(vt[i].aempty));
      chk($sformatf("v%0d.wack", i),   32'(b_wack),   32'(vt[i].wack));
      chk($sformatf("v%0d.ovf", i),    32'(b_ovf),    32'(vt[i].ovf));
      chk($sformatf("v%0d.unf", i),    32'(b_unf),    32'(vt[i].unf));
      chk($sformatf("v%0d.dvld", i),   32'(b_dvld),   32'(vt[i].dvld));
      if (vt[i].qchk) begin
        chk($sformatf("v%0d.q", i), 32'(b_q), 32'(vt[i].q));
      end
    end

    // FWFT pointer wrap: keep two words resident through 12 write/read pairs
    b_flush = 1'b0; b_re = 1'b0; b_we = 1'b1; b_data = 16'h0200;
    step();
    b_data = 16'h0201;
    step();
    chk("wrap0.q", 32'(b_q), 32'h0200);
    b_re = 1'b1;
    for (int k = 0; k < 12; k++) begin
      b_data = 16'(16'h0202 + k);
      step();
      chk($sformatf("wrap%0d.q", k + 1), 32'(b_q), 32'(16'h0201 + k));
      chk($sformatf("wrap%0d.count", k + 1), 32'(b_count), 32'd2);
    end
    b_we = 1'b0; b_re = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
